// File: rtl/dll_tx_seq_ctrl_pkg.sv
// Shared sequence-number types and modulo-4096 helpers for the DLL transmit path.
package dll_tx_package;

    localparam int SEQ_WIDTH   = 12;
    localparam int SEQ_MOD     = 4096;
    localparam int HALF_WINDOW = 2048;

    typedef logic [SEQ_WIDTH-1:0] seq_num_t;

    // Forward distance from b to a, modulo the sequence space.
    function automatic seq_num_t seq_diff(input seq_num_t a, input seq_num_t b);
        return seq_num_t'((int'(a) - int'(b) + SEQ_MOD) % SEQ_MOD);
    endfunction

endpackage

// File: rtl/dll_tx_seq_ctrl_if.sv
// TLP beat stream, LCRC-side stream and Ack/Nak result bundle of the DLL sequencer.
interface dll_tx_seq_ctrl_if
    import dll_tx_package::*;
#(
    parameter int DLL_TLP_WIDTH = 256,
    parameter int VB_WIDTH      = 5
) ();

    logic                     tlp_valid_i;
    logic                     sop_i;
    logic                     eop_i;
    logic [VB_WIDTH-1:0]      valid_bytes_i;
    logic [DLL_TLP_WIDTH-1:0] tlp_i;
    logic                     halt_o;

    logic                     out_ready_i;
    logic                     replay_active_i;
    logic                     tlp_valid_o;
    logic                     sop_o;
    logic                     eop_o;
    logic [VB_WIDTH-1:0]      valid_bytes_o;
    logic [DLL_TLP_WIDTH-1:0] tlp_o;
    seq_num_t                 seq_num_o;

    logic                     ack_valid_i;
    logic                     ack_nak_i;
    seq_num_t                 ack_seq_i;
    seq_num_t                 next_tx_seq_o;
    seq_num_t                 ackd_seq_o;
    seq_num_t                 outstanding_o;
    logic                     replay_req_o;
    seq_num_t                 replay_seq_o;
    logic                     dllp_err_o;

    // Environment side: fragmentation, LCRC stage and DLLP receiver.
    modport master (
        output tlp_valid_i, sop_i, eop_i, valid_bytes_i, tlp_i,
        output out_ready_i, replay_active_i, ack_valid_i, ack_nak_i, ack_seq_i,
        input  halt_o, tlp_valid_o, sop_o, eop_o, valid_bytes_o, tlp_o, seq_num_o,
        input  next_tx_seq_o, ackd_seq_o, outstanding_o, replay_req_o, replay_seq_o, dllp_err_o
    );

    modport slave (
        input  tlp_valid_i, sop_i, eop_i, valid_bytes_i, tlp_i,
        input  out_ready_i, replay_active_i, ack_valid_i, ack_nak_i, ack_seq_i,
        output halt_o, tlp_valid_o, sop_o, eop_o, valid_bytes_o, tlp_o, seq_num_o,
        output next_tx_seq_o, ackd_seq_o, outstanding_o, replay_req_o, replay_seq_o, dllp_err_o
    );

endinterface

// File: rtl/dll_tx_seq_ctrl_skid_fifo.sv
// Two-entry beat FIFO absorbing the one beat upstream may send after halt rises.
module dll_tx_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count,
    output logic [1:0]       count_nxt
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en && (count != 2'd0);
    assign do_wr   = wr_en && ((count != 2'd2) || do_rd);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_wr) wr_ptr <= ~wr_ptr;
            if (do_rd) rd_ptr <= ~rd_ptr;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!arst)
        !(wr_en && (count == 2'd2) && !rd_en));

endmodule

// File: rtl/dll_tx_seq_ctrl.sv
// DLL transmit sequencer: numbers TLPs, enforces the replay window, tracks Ack/Nak.
module dll_tx_seq_ctrl
    import dll_tx_package::*;
#(
    parameter int DLL_TLP_WIDTH   = 256,
    parameter int VB_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = 2048
) (
    input  logic               clk,
    input  logic               arst,
    dll_tx_seq_ctrl_if.slave   bus
);

    localparam int       ENTRY_W     = DLL_TLP_WIDTH + VB_WIDTH + 2;
    localparam seq_num_t MAX_OUT_SEQ = seq_num_t'(MAX_OUTSTANDING);
    localparam seq_num_t HALF_SEQ    = seq_num_t'(HALF_WINDOW);

    logic [ENTRY_W-1:0]       wr_data;
    logic [ENTRY_W-1:0]       head;
    logic [1:0]               count;
    logic [1:0]               count_nxt;
    logic                     head_sop;
    logic                     head_eop;
    logic [VB_WIDTH-1:0]      head_vb;
    logic [DLL_TLP_WIDTH-1:0] head_data;
    logic                     not_empty;
    logic                     window_ok;
    logic                     issue;

    seq_num_t nts;
    seq_num_t ackd;
    seq_num_t cur_seq;
    seq_num_t outstanding;
    seq_num_t ack_seq;
    logic     ack_dup;
    logic     ack_in_range;

    logic     halt_p1;
    logic     replay_req_p1;
    logic     dllp_err_p1;
    seq_num_t replay_seq_p1;

    assign wr_data = {bus.sop_i, bus.eop_i, bus.valid_bytes_i, bus.tlp_i};

    dll_tx_skid_fifo #(.WIDTH(ENTRY_W)) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .wr_en     (bus.tlp_valid_i),
        .wr_data   (wr_data),
        .rd_en     (issue),
        .rd_data   (head),
        .count     (count),
        .count_nxt (count_nxt)
    );

    assign {head_sop, head_eop, head_vb, head_data} = head;
    assign not_empty   = (count != 2'd0);
    assign outstanding = seq_diff(nts, ackd) - 12'd1;
    // Window gates only the start of a TLP; continuation beats always flow.
    assign window_ok   = !head_sop || (outstanding < MAX_OUT_SEQ);
    assign issue       = not_empty && bus.out_ready_i && !bus.replay_active_i && window_ok;

    assign ack_seq      = bus.ack_seq_i;
    assign ack_dup      = (ack_seq == ackd);
    assign ack_in_range = (seq_diff(nts - 12'd1, ack_seq) < HALF_SEQ) &&
                          (seq_diff(ack_seq, ackd) < HALF_SEQ);

    // Head beat is gated to zero when empty so stale storage never leaks out.
    assign bus.tlp_valid_o   = issue;
    assign bus.sop_o         = not_empty && head_sop;
    assign bus.eop_o         = not_empty && head_eop;
    assign bus.valid_bytes_o = not_empty ? head_vb : '0;
    assign bus.tlp_o         = not_empty ? head_data : '0;
    assign bus.seq_num_o     = (not_empty && head_sop) ? nts : cur_seq;
    assign bus.halt_o        = halt_p1;
    assign bus.next_tx_seq_o = nts;
    assign bus.ackd_seq_o    = ackd;
    assign bus.outstanding_o = outstanding;
    assign bus.replay_req_o  = replay_req_p1;
    assign bus.replay_seq_o  = replay_seq_p1;
    assign bus.dllp_err_o    = dllp_err_p1;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            nts           <= '0;
            ackd          <= '1;
            cur_seq       <= '0;
            halt_p1       <= 1'b0;
            replay_req_p1 <= 1'b0;
            replay_seq_p1 <= '0;
            dllp_err_p1   <= 1'b0;
        end else begin
            halt_p1       <= (count_nxt != 2'd0) && !issue;
            replay_req_p1 <= 1'b0;
            dllp_err_p1   <= 1'b0;
            if (issue && head_sop) begin
                nts     <= nts + 12'd1;
                cur_seq <= nts;
            end
            // A duplicate is always accepted, even when the window is saturated.
            if (bus.ack_valid_i) begin
                if (ack_dup || ack_in_range) begin
                    ackd <= ack_seq;
                    if (bus.ack_nak_i) begin
                        replay_req_p1 <= 1'b1;
                        replay_seq_p1 <= ack_seq + 12'd1;
                    end
                end else begin
                    dllp_err_p1 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dll_tx_seq_ctrl.sv
// Scoreboard bench for dll_tx_seq_ctrl with a 4-TLP replay window.
module tb_dll_tx_seq_ctrl;

    localparam int TW   = 64;
    localparam int VW   = 5;
    localparam int MAXO = 4;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [VW-1:0] vb;
        logic [TW-1:0] data;
        logic [11:0]   seq;
    } beat_t;

    logic  clk  = 1'b0;
    logic  arst = 1'b0;
    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];
    beat_t mon_e;
    logic [11:0] tlp_cnt = '0;

    always #5 clk = ~clk;

    dll_tx_seq_ctrl_if #(.DLL_TLP_WIDTH(TW), .VB_WIDTH(VW)) bus ();

    dll_tx_seq_ctrl #(
        .DLL_TLP_WIDTH   (TW),
        .VB_WIDTH        (VW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic sop, input logic eop);
        int    n = 0;
        beat_t b;
        while (bus.halt_o && n < 100) begin
            cycle();
            n++;
        end
        if (bus.halt_o) check("halt_timeout", bus.halt_o, 1'b0);
        b.sop  = sop;
        b.eop  = eop;
        b.vb   = VW'($urandom_range(0, 31));
        b.data = {$urandom, $urandom};
        b.seq  = tlp_cnt;
        if (eop) tlp_cnt = tlp_cnt + 12'd1;
        sb.push_back(b);
        bus.tlp_valid_i   = 1'b1;
        bus.sop_i         = sop;
        bus.eop_i         = eop;
        bus.valid_bytes_i = b.vb;
        bus.tlp_i         = b.data;
        cycle();
        bus.tlp_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic send_ack(input logic nak, input logic [11:0] s);
        bus.ack_valid_i = 1'b1;
        bus.ack_nak_i   = nak;
        bus.ack_seq_i   = s;
        cycle();
        bus.ack_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b0;
        bus.tlp_valid_i = 1'b0;
        bus.ack_valid_i = 1'b0;
        sb.delete();
        tlp_cnt = '0;
        repeat (2) cycle();
        arst = 1'b1;
        cycle();
    endtask

    // Every issued beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arst && bus.tlp_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", bus.tlp_valid_o, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("beat_sop",  bus.sop_o, mon_e.sop);
                check("beat_eop",  bus.eop_o, mon_e.eop);
                check("beat_vb",   bus.valid_bytes_o, mon_e.vb);
                check("beat_data", bus.tlp_o, mon_e.data);
                check("beat_seq",  bus.seq_num_o, mon_e.seq);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.tlp_valid_i     = 1'b0;
        bus.sop_i           = 1'b0;
        bus.eop_i           = 1'b0;
        bus.valid_bytes_i   = '0;
        bus.tlp_i           = '0;
        bus.out_ready_i     = 1'b1;
        bus.replay_active_i = 1'b0;
        bus.ack_valid_i     = 1'b0;
        bus.ack_nak_i       = 1'b0;
        bus.ack_seq_i       = '0;
        #12;
        check("rst_halt",     bus.halt_o, 1'b0);
        check("rst_valid",    bus.tlp_valid_o, 1'b0);
        check("rst_seq",      bus.seq_num_o, 12'd0);
        check("rst_nts",      bus.next_tx_seq_o, 12'd0);
        check("rst_ackd",     bus.ackd_seq_o, 12'd4095);
        check("rst_outst",    bus.outstanding_o, 12'd0);
        check("rst_replay",   bus.replay_req_o, 1'b0);
        check("rst_dllp_err", bus.dllp_err_o, 1'b0);
        arst = 1'b1;
        cycle();

        // Three-beat TLP with the LCRC stage always ready.
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        wait_drain();
        check("t1_nts",   bus.next_tx_seq_o, 12'd1);
        check("t1_outst", bus.outstanding_o, 12'd1);

        // Five-beat TLP with a four-cycle downstream stall in the middle.
        fork
            begin
                send_beat(1'b1, 1'b0);
                for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0);
                send_beat(1'b0, 1'b1);
            end
            begin
                repeat (2) cycle();
                bus.out_ready_i = 1'b0;
                repeat (4) cycle();
                check("t2_halt_stall", bus.halt_o, 1'b1);
                check("t2_no_issue",   bus.tlp_valid_o, 1'b0);
                bus.out_ready_i = 1'b1;
            end
        join
        wait_drain();
        check("t2_nts",   bus.next_tx_seq_o, 12'd2);
        check("t2_outst", bus.outstanding_o, 12'd2);

        // Window limit: fifth TLP held until an Ack frees space.
        do_reset();
        for (int i = 0; i < 5; i++) send_beat(1'b1, 1'b1);
        repeat (3) cycle();
        check("t3_halt",    bus.halt_o, 1'b1);
        check("t3_held",    bus.tlp_valid_o, 1'b0);
        check("t3_nts",     bus.next_tx_seq_o, 12'd4);
        check("t3_outst",   bus.outstanding_o, 12'd4);
        check("t3_pending", sb.size(), 1);
        send_ack(1'b0, 12'd1);
        check("t3_ackd", bus.ackd_seq_o, 12'd1);
        cycle();
        check("t3_nts_after", bus.next_tx_seq_o, 12'd5);
        check("t3_pending_after", sb.size(), 0);
        send_beat(1'b1, 1'b1);
        wait_drain();
        check("t3_nts6", bus.next_tx_seq_o, 12'd6);

        // Nak in the middle of the window.
        do_reset();
        send_beat(1'b1, 1'b1);
        wait_drain();
        send_ack(1'b0, 12'd0);
        check("t4_ackd0", bus.ackd_seq_o, 12'd0);
        for (int i = 0; i < 4; i++) send_beat(1'b1, 1'b1);
        wait_drain();
        check("t4_nts", bus.next_tx_seq_o, 12'd5);
        send_ack(1'b1, 12'd2);
        check("t4_ackd",       bus.ackd_seq_o, 12'd2);
        check("t4_replay_req", bus.replay_req_o, 1'b1);
        check("t4_replay_seq", bus.replay_seq_o, 12'd3);
        check("t4_outst",      bus.outstanding_o, 12'd2);
        check("t4_no_err",     bus.dllp_err_o, 1'b0);
        cycle();
        check("t4_replay_pulse", bus.replay_req_o, 1'b0);

        // Out-of-range Ack, duplicate Ack and replay hold.
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b1);
        wait_drain();
        check("t5_nts", bus.next_tx_seq_o, 12'd3);
        send_ack(1'b0, 12'd100);
        check("t5_err",      bus.dllp_err_o, 1'b1);
        check("t5_ackd_bad", bus.ackd_seq_o, 12'd4095);
        cycle();
        check("t5_err_pulse", bus.dllp_err_o, 1'b0);
        send_ack(1'b0, 12'd4095);
        check("t5_dup_err",  bus.dllp_err_o, 1'b0);
        check("t5_dup_ackd", bus.ackd_seq_o, 12'd4095);
        bus.replay_active_i = 1'b1;
        send_beat(1'b1, 1'b1);
        repeat (3) cycle();
        check("t5_replay_hold", bus.tlp_valid_o, 1'b0);
        check("t5_nts_hold",    bus.next_tx_seq_o, 12'd3);
        bus.replay_active_i = 1'b0;
        wait_drain();
        check("t5_nts_after", bus.next_tx_seq_o, 12'd4);

        // Sequence wrap through 4095 back to 0.
        do_reset();
        for (int i = 0; i < 4095; i++) begin
            send_beat(1'b1, 1'b1);
            wait_drain();
            send_ack(1'b0, 12'(i));
        end
        check("t6_nts4095", bus.next_tx_seq_o, 12'd4095);
        send_beat(1'b1, 1'b1);
        wait_drain();
        check("t6_nts_wrap", bus.next_tx_seq_o, 12'd0);
        send_ack(1'b0, 12'd4095);
        send_beat(1'b1, 1'b1);
        wait_drain();
        send_ack(1'b0, 12'd0);
        check("t6_ackd0",   bus.ackd_seq_o, 12'd0);
        check("t6_no_err",  bus.dllp_err_o, 1'b0);
        check("t6_outst",   bus.outstanding_o, 12'd0);

        // Asynchronous reset in the middle of a TLP.
        send_beat(1'b1, 1'b0);
        wait_drain();
        send_beat(1'b0, 1'b0);
        #2;
        arst = 1'b0;
        bus.tlp_valid_i = 1'b0;
        sb.delete();
        tlp_cnt = '0;
        #1;
        check("t7_valid", bus.tlp_valid_o, 1'b0);
        check("t7_sop",   bus.sop_o, 1'b0);
        check("t7_data",  bus.tlp_o, 64'd0);
        check("t7_seq",   bus.seq_num_o, 12'd0);
        check("t7_nts",   bus.next_tx_seq_o, 12'd0);
        check("t7_ackd",  bus.ackd_seq_o, 12'd4095);
        check("t7_halt",  bus.halt_o, 1'b0);
        repeat (2) cycle();
        arst = 1'b1;
        cycle();
        send_beat(1'b1, 1'b1);
        wait_drain();
        check("t7_nts_after", bus.next_tx_seq_o, 12'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dll_tx_seq_ctrl.md
Name: dll_tx_seq_ctrl

Overview:
First DLL-side stage downstream of the TL transmit path (fragmentation output). Accepts TLP beats from the fragmentation Halt/sop/eop interface and assigns a 12-bit sequence number to each TLP as it is issued to the LCRC/framing stage. Tracks NEXT_TRANSMIT_SEQ and ACKD_SEQ, enforces the outstanding-TLP window and processes Ack/Nak DLLP results. Back-pressures the TL through halt_o.

Parameters:
DLL_TLP_WIDTH, 256, TLP beat width in bits (from Fragmentation_Package).
VB_WIDTH, 5, width of the valid-bytes encoding.
MAX_OUTSTANDING, 2048, maximum unacknowledged TLPs (retry-buffer capacity); legal range 2..2048.

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-low
tlp_valid_i  in  1  beat valid from fragmentation
sop_i  in  1  first beat of TLP
eop_i  in  1  last beat of TLP
valid_bytes_i  in  VB_WIDTH  valid-bytes encoding of beat
tlp_i  in  DLL_TLP_WIDTH  beat data
halt_o  out  1  stall request to fragmentation (registered)
out_ready_i  in  1  downstream (LCRC) accepts beat
replay_active_i  in  1  replay engine owns the link; hold new TLPs
tlp_valid_o  out  1  beat valid to LCRC stage
sop_o  out  1  first beat
eop_o  out  1  last beat
valid_bytes_o  out  VB_WIDTH  pass-through
tlp_o  out  DLL_TLP_WIDTH  pass-through
seq_num_o  out  12  sequence number of current TLP (all beats)
ack_valid_i  in  1  Ack/Nak DLLP received
ack_nak_i  in  1  0 = Ack, 1 = Nak
ack_seq_i  in  12  AckNak_Seq_Num
next_tx_seq_o  out  12  NEXT_TRANSMIT_SEQ
ackd_seq_o  out  12  ACKD_SEQ
outstanding_o  out  12  (NTS − ACKD − 1) mod 4096
replay_req_o  out  1  one-cycle pulse on valid Nak
replay_seq_o  out  12  first sequence number to replay (ack_seq_i+1)
dllp_err_o  out  1  one-cycle pulse on out-of-range Ack/Nak

Behaviour:
- Reset (arst low, async): NTS=0, ACKD=4095, FIFO empty, all outputs 0 except ackd_seq_o=4095; an in-progress TLP is discarded.
- Input path: 2-entry FIFO {sop,eop,vb,data}; beat written when tlp_valid_i=1. Writing into a full FIFO is a protocol violation (assertion).
- halt_o registered: next value = 1 if post-update FIFO count ≥1 and the head is not issued this cycle, else 0. Upstream may deliver at most one beat after halt_o rises.
- Output: head issued (tlp_valid_o=1) when FIFO non-empty, out_ready_i=1, replay_active_i=0, and (head not sop or outstanding < MAX_OUTSTANDING). Outputs are driven combinationally from the FIFO head: an accepted beat leaves the next cycle; latency is 1 cycle input-to-output with an empty FIFO.
- Window gate applies only at sop. A TLP already started continues through eop regardless of the window.
- Sequence: on sop issue, seq_num_o=NTS and the value is held for the TLP; NTS<=NTS+1 mod 4096 on the sop beat.
- Ack/Nak acceptance, s=ack_seq_i: valid if (NTS−1−s) mod 4096 < 2048 and (s−ACKD) mod 4096 < 2048.
  - Valid Ack: ACKD<=s.
  - Valid Nak: ACKD<=s, replay_req_o pulse, replay_seq_o=s+1 mod 4096.
  - s==ACKD: duplicate, no state change and no error (a Nak still pulses replay_req_o).
  - Otherwise: dllp_err_o pulse, state unchanged.
- Simultaneous sop issue and Ack: the window check uses pre-update values; NTS and ACKD both update; outstanding_o reflects both on the next cycle.
- All arithmetic is modulo 4096 on 12-bit unsigned values.

Decomposition:
- Package dll_tx_package: SEQ_WIDTH=12, SEQ_MOD=4096, HALF_WINDOW=2048, typedef seq_num_t, function seq_diff(a,b).
- Sub-module dll_tx_skid_fifo: 2-entry FIFO with count output.

Test Plan:
- 3-beat TLP, out_ready_i=1 -> beats out cycles 1–3, seq_num_o=0, next_tx_seq_o=1, outstanding_o=1.
- 5-beat TLP with out_ready_i low for 4 cycles mid-TLP -> halt_o high the cycle after the FIFO holds a beat; all 5 beats out in order, none lost or duplicated.
- MAX_OUTSTANDING=4, six 1-beat TLPs, no Ack -> seq 0–3 issued, 5th held, halt_o=1; Ack seq 1 -> 5th issued with seq 4 the next cycle.
- NTS=5, ACKD=0, Nak seq 2 -> ackd_seq_o=2, replay_req_o pulse, replay_seq_o=3, outstanding_o=2.
- ACKD=4095, NTS=3: Ack 100 -> dllp_err_o pulse, no change; Ack 4095 -> no error, no change; replay_active_i=1 -> no issue.
- Wrap: advance to NTS=4095, issue -> seq 4095 then 0; Ack 0 accepted, ACKD=0. Reset asserted mid-TLP -> all outputs return to reset values immediately.
